// File: rtl/bus_pkg.sv
// Shared bus definitions: packet layout, broadcast ID and FIFO operation tags.
package bus_pkg;

   localparam int unsigned PCKG_SZ      = 16;
   localparam int unsigned ID_W         = 8;
   localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

   typedef struct packed {
      logic [ID_W-1:0]         dest;
      logic [PCKG_SZ-ID_W-1:0] payload;
   } pkt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR    = 2'd1,
      RD    = 2'd2,
      WR_RD = 2'd3
   } fifo_op_e;

endpackage

// File: rtl/bus_tx_fifo_mem.sv
// Register array for the transmit FIFO: one synchronous write port, asynchronous read.
module bus_tx_fifo_mem #(
   parameter int unsigned width = 16,
   parameter int unsigned depth = 8,
   parameter int unsigned ptr_w = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ptr_w-1:0] waddr,
   input  logic [width-1:0] wdata,
   input  logic [ptr_w-1:0] raddr,
   output logic [width-1:0] rdata
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_tx_fifo.sv
// Per-device transmit FIFO feeding one bus source port (pndng/pop/D_pop handshake).
// Optional BUS_TX_FIFO_STATS_EN adds saturating tx_total/drop_total counters.
module bus_tx_fifo
   import bus_pkg::*;
#(
   parameter int unsigned pckg_sz = 16,
   parameter int unsigned depth   = 8,
   parameter int unsigned cnt_w   = $clog2(depth + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   output logic               full,
   output logic               pndng,
   input  logic               pop,
   output logic [pckg_sz-1:0] D_pop,
   output logic [cnt_w-1:0]   count,
   output logic               overflow,
   output logic               underflow
`ifdef BUS_TX_FIFO_STATS_EN
   ,
   output logic [31:0]        tx_total,
   output logic [31:0]        drop_total
`endif
);

   localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(depth - 1);
   localparam logic [cnt_w-1:0] CNT_FULL = cnt_w'(depth);

   logic [PTR_W-1:0]   rd, wr, rd_next, wr_next;
   logic [cnt_w-1:0]   count_next;
   logic               do_push, do_pop, drop, empty_pop;
   logic [pckg_sz-1:0] head;

   bus_tx_fifo_mem #(
      .width (pckg_sz),
      .depth (depth),
      .ptr_w (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr),
      .wdata (D_push),
      .raddr (rd),
      .rdata (head)
   );

   // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
   always_comb begin
      do_pop     = 1'b0;
      do_push    = 1'b0;
      drop       = 1'b0;
      empty_pop  = 1'b0;
      rd_next    = rd;
      wr_next    = wr;
      count_next = count;

      do_pop    = pop && (count != '0);
      empty_pop = pop && (count == '0);
      do_push   = push && ((count != CNT_FULL) || do_pop);
      drop      = push && !do_push;

      if (do_pop)  rd_next = (rd == PTR_LAST) ? '0 : rd + PTR_W'(1);
      if (do_push) wr_next = (wr == PTR_LAST) ? '0 : wr + PTR_W'(1);

      if (do_push && !do_pop)      count_next = count + cnt_w'(1);
      else if (do_pop && !do_push) count_next = count - cnt_w'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd        <= '0;
         wr        <= '0;
         count     <= '0;
         pndng     <= 1'b0;
         full      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         rd        <= rd_next;
         wr        <= wr_next;
         count     <= count_next;
         pndng     <= (count_next != '0);
         full      <= (count_next == CNT_FULL);
         if (drop)      overflow  <= 1'b1;
         if (empty_pop) underflow <= 1'b1;
      end
   end

   // Head is masked while empty so stale memory never reaches the bus.
   assign D_pop = pndng ? head : '0;

`ifdef BUS_TX_FIFO_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_total   <= '0;
         drop_total <= '0;
      end else begin
         if (do_pop && (tx_total != '1))  tx_total   <= tx_total + 32'd1;
         if (drop && (drop_total != '1))  drop_total <= drop_total + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bus_tx_fifo.sv
// Directed self-checking bench for bus_tx_fifo (depth 8, 16-bit packets).
module tb_bus_tx_fifo;
   import bus_pkg::*;

   localparam int unsigned W = 16;
   localparam int unsigned D = 8;
   localparam int unsigned CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          push = 1'b0;
   logic [W-1:0]  D_push = '0;
   logic          full;
   logic          pndng;
   logic          pop = 1'b0;
   logic [W-1:0]  D_pop;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;
`ifdef BUS_TX_FIFO_STATS_EN
   logic [31:0]   tx_total;
   logic [31:0]   drop_total;
`endif

   int vectors = 0;
   int miscompares = 0;

   bus_tx_fifo #(.pckg_sz(W), .depth(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .D_push    (D_push),
      .full      (full),
      .pndng     (pndng),
      .pop       (pop),
      .D_pop     (D_pop),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
`ifdef BUS_TX_FIFO_STATS_EN
      ,
      .tx_total  (tx_total),
      .drop_total(drop_total)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given strobes; outputs are sampled 1 time unit later.
   task automatic step(input logic p, input logic [W-1:0] d, input logic q);
      push   = p;
      D_push = d;
      pop    = q;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, '0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] val;
      pkt_t         pk;

      // Reset state
      do_reset();
      chk("rst_pndng", 32'(pndng), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_udf", 32'(underflow), 32'd0);
      chk("rst_dpop", 32'(D_pop), 32'd0);

      // Single push then pop
      step(1'b1, 16'h0A55, 1'b0);
      chk("one_pndng", 32'(pndng), 32'd1);
      chk("one_dpop", 32'(D_pop), 32'h0A55);
      chk("one_count", 32'(count), 32'd1);
      step(1'b0, '0, 1'b1);
      chk("one_pop_pndng", 32'(pndng), 32'd0);
      chk("one_pop_dpop", 32'(D_pop), 32'd0);

      // Fill to depth, overflow, drain in order
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + W'(i), 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd8);
      step(1'b1, 16'hDEAD, 1'b0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_full", 32'(full), 32'd1);
      for (int i = 0; i < 8; i++) begin
         chk("drain_dpop", 32'(D_pop), 32'h0100 + 32'(i));
         step(1'b0, '0, 1'b1);
      end
      chk("drain_pndng", 32'(pndng), 32'd0);
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_udf", 32'(underflow), 32'd0);

      // Push with pop while full
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0200 + W'(i), 1'b0);
      step(1'b1, 16'hBEEF, 1'b1);
      chk("fpp_full", 32'(full), 32'd1);
      chk("fpp_count", 32'(count), 32'd8);
      for (int i = 1; i < 8; i++) begin
         chk("fpp_dpop", 32'(D_pop), 32'h0200 + 32'(i));
         step(1'b0, '0, 1'b1);
      end
      chk("fpp_last", 32'(D_pop), 32'hBEEF);
      chk("fpp_last_cnt", 32'(count), 32'd1);
      step(1'b0, '0, 1'b1);
      chk("fpp_empty", 32'(pndng), 32'd0);

      // Underflow, then push+pop on empty
      step(1'b0, '0, 1'b1);
      chk("udf_flag", 32'(underflow), 32'd1);
      chk("udf_count", 32'(count), 32'd0);
      step(1'b1, 16'h1234, 1'b1);
      chk("epp_count", 32'(count), 32'd1);
      chk("epp_dpop", 32'(D_pop), 32'h1234);
      step(1'b0, '0, 1'b1);

      // Pointer wrap with streaming push/pop pairs, including a broadcast packet
      prev = 16'h3000;
      step(1'b1, prev, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         pk.dest    = 8'h30;
         pk.payload = 8'(i);
         val = (i == 10) ? {BROADCAST_ID, 8'h3C} : W'(pk);
         chk("wrap_dpop", 32'(D_pop), 32'(prev));
         step(1'b1, val, 1'b1);
         prev = val;
      end
      chk("wrap_last", 32'(D_pop), 32'h3014);
      chk("wrap_count", 32'(count), 32'd1);

      // Re-check broadcast delivery explicitly at the head
      step(1'b0, '0, 1'b1);
      step(1'b1, 16'hFF3C, 1'b0);
      chk("bcast_dpop", 32'(D_pop), 32'hFF3C);
      step(1'b0, '0, 1'b1);

      // Mid-operation reset at count=5, with a push in the reset cycle
      for (int i = 0; i < 5; i++) step(1'b1, 16'h4000 + W'(i), 1'b0);
      chk("pre_rst_count", 32'(count), 32'd5);
      reset = 1'b1;
      step(1'b1, 16'h4444, 1'b0);
      reset = 1'b0;
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_pndng", 32'(pndng), 32'd0);
      chk("mrst_flags", 32'({overflow, underflow, full}), 32'd0);
      chk("mrst_dpop", 32'(D_pop), 32'd0);
      step(1'b1, 16'h5555, 1'b0);
      chk("post_rst_count", 32'(count), 32'd1);
      chk("post_rst_dpop", 32'(D_pop), 32'h5555);

`ifdef BUS_TX_FIFO_STATS_EN
      do_reset();
      chk("st_rst_tx", tx_total, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 16'h6000 + W'(i), 1'b0);
         step(1'b0, '0, 1'b1);
      end
      step(1'b0, '0, 1'b1);
      chk("st_tx", tx_total, 32'd10);
      for (int i = 0; i < 11; i++) step(1'b1, 16'h7000 + W'(i), 1'b0);
      chk("st_drop", drop_total, 32'd3);
      do_reset();
      chk("st_clr_tx", tx_total, 32'd0);
      chk("st_clr_drop", drop_total, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_tx_fifo.md
Name: bus_tx_fifo

Overview:
- Per-device transmit FIFO between a device/agent write port and one source port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- Buffers pckg_sz-bit packets and presents the head packet to the bus through the pndng/pop/D_pop handshake.
- The top level instantiates one copy per driver (drvrs copies) and connects each to bit/slice [id] of the bus pndng, pop and D_pop vectors.

Parameters:
- pckg_sz, 16, packet width in bits; upper 8 bits are the destination ID, with {8{1'b1}} meaning broadcast.
- depth, 8, FIFO entries; any value >= 2; need not be a power of two.
- cnt_w, $clog2(depth+1), width of the occupancy count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  device write strobe.
- D_push  in  pckg_sz  device write data, sampled when push=1.
- full  out  1  FIFO holds depth entries.
- pndng  out  1  FIFO non-empty; head packet valid on D_pop.
- pop  in  1  bus read strobe; consumes the head packet.
- D_pop  out  pckg_sz  head packet, first-word fall-through.
- count  out  cnt_w  current occupancy.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop arrived while empty.

Behaviour:
- Reset: synchronous; every output and internal state is cleared at the first rising edge with reset=1.
  - Reset values: pndng=0, full=0, count=0, overflow=0, underflow=0, D_pop=0, read/write pointers=0.
  - Reset takes priority over push and pop in the same cycle; stored contents are discarded.
- Storage: circular buffer with read pointer rd and write pointer wr. Each pointer wraps from depth-1 to 0 with an explicit compare, not modulo-2^n.
- Occupancy is tracked by count. Flags are registered or derived purely from count:
  - pndng = (count != 0)
  - full = (count == depth)
- Write latency: a push at edge N makes pndng=1 and D_pop=D_push visible after edge N (one cycle) when the FIFO was empty.
- D_pop always equals mem[rd] while pndng=1 and holds 0 while empty. No combinational path from pop to D_pop within a cycle.
- Pop: pop=1 with pndng=1 advances rd at the edge. The next head appears on D_pop in the following cycle.
- Push/pop combinations at one edge:
  - push only, not full: write at wr, wr++, count++.
  - push only, full: write dropped, overflow<=1, state unchanged.
  - pop only, non-empty: rd++, count--.
  - pop only, empty: ignored, underflow<=1.
  - push and pop, non-empty: both pointers advance, count unchanged. Also legal when full: the pop frees a slot, the write lands, full stays 1.
  - push and pop, empty: the pop is an underflow (flag set); the push is accepted; count becomes 1.
- overflow and underflow clear only on reset.
- Packet content is opaque: no checking of the destination ID; broadcast packets pass untouched.
- Mid-operation reset (e.g. count=5): the next cycle shows count=0 and pndng=0. A push on the first cycle after reset deassertion is accepted normally.

Optional Feature:
- Macro: BUS_TX_FIFO_STATS_EN.
- Defined: adds 32-bit outputs tx_total and drop_total.
  - tx_total increments on every accepted pop.
  - drop_total increments on every dropped push.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package bus_pkg:
  - BROADCAST_ID = 8'hFF
  - ID_W = 8
  - pkt_t typedef: struct {dest[ID_W], payload[pckg_sz-ID_W]}, used by benches for field access.
  - fifo_op_e enum {IDLE, WR, RD, WR_RD} for monitor/scoreboard reporting.
- One sub-module is natural: bus_tx_fifo_mem, a parameterised register array with one write port and an asynchronous read at rd. Pointer/count control stays in bus_tx_fifo.

Test Plan:
- Reset then push 16'h0A55 once:
  - one cycle later pndng=1, D_pop=16'h0A55, count=1.
  - pop once: next cycle pndng=0, D_pop=0.
- Push 8 packets 16'h0100..16'h0107 (depth=8):
  - full=1 after the 8th, count=8.
  - a 9th push 16'hDEAD gives overflow=1, count stays 8.
  - 8 pops return 0100..0107 in order.
- Full FIFO, push 16'hBEEF together with pop:
  - full stays 1, count stays 8.
  - the head advances; 16'hBEEF is returned last after 7 more pops.
- Empty FIFO, pop alone: underflow=1, count=0. Push and pop together on empty: count=1, D_pop=pushed value.
- Pointer wrap:
  - 20 push/pop pairs with fixed spacing, plus a broadcast packet 16'hFF3C: data intact across the wrap, FF3C delivered unchanged.
  - reset asserted at count=5: count=0, flags clear next cycle.
- With BUS_TX_FIFO_STATS_EN defined:
  - 10 accepted pops give tx_total=10.
  - 3 dropped pushes give drop_total=3.
  - reset clears both counters.
